// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared state encoding and request-bus width for the data-SRAM responder
package data_sram_resp_pkg;

  // Width of the {en, wen, addr, wdata} request bundle seen at SoC level.
  localparam int DSRAM_WD = 69;

  typedef enum logic {
    DSRAM_ST_INIT = 1'b0,
    DSRAM_ST_RUN  = 1'b1
  } dsram_state_t;

endpackage

// File: rtl/dsram_byte_bank.sv
// rtl/dsram_byte_bank.sv - one 8-bit byte lane, single port, read-first, registered output
module dsram_byte_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-SRAM responder: zero-fill FSM, range check, error capture, 4 byte banks
// Optional access counters are built when DSRAM_PERF_CNT_EN is defined.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        init_done,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

  dsram_state_t          state, state_nxt;
  logic [DEPTH_LOG2-1:0] init_ptr;
  logic [DSRAM_WD-1:0]   req;
  logic                  req_en;
  logic [3:0]            req_wen;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  run, hit, acc, miss;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           bank_q;
  logic                  rdata_zero;
  logic                  unused_addr_lsb;

  assign req = {sram_en, sram_wen, sram_addr, sram_wdata};
  assign {req_en, req_wen, req_addr, req_wdata} = req;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign run  = (state == DSRAM_ST_RUN);
  assign hit  = (req_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign idx  = req_addr[DEPTH_LOG2+1:2];
  assign acc  = run && req_en && hit;
  assign miss = run && req_en && !hit;

  always_ff @(posedge clk) begin
    if (rst) state <= DSRAM_ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DSRAM_ST_INIT: if (init_ptr == PTR_LAST) state_nxt = DSRAM_ST_RUN;
      DSRAM_ST_RUN:  state_nxt = DSRAM_ST_RUN;
      default:       state_nxt = DSRAM_ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       init_ptr <= '0;
    else if (!run) init_ptr <= init_ptr + 1'b1;
  end

  assign init_done = run;

  // During zero-fill the banks are driven by the fill pointer; requests never reach them.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    dsram_byte_bank #(.AW(DEPTH_LOG2)) u_bank (
      .clk   (clk),
      .en    (run ? acc : 1'b1),
      .we    (run ? req_wen[i] : 1'b1),
      .addr  (run ? idx : init_ptr),
      .wdata (run ? req_wdata[8*i +: 8] : 8'h00),
      .rdata (bank_q[8*i +: 8])
    );
  end

  // Bank output is only meaningful after a hit; reset, fill and misses force zero.
  always_ff @(posedge clk) begin
    if (rst || !run)  rdata_zero <= 1'b1;
    else if (req_en)  rdata_zero <= !hit;
  end

  assign sram_rdata = rdata_zero ? 32'h0 : bank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_addr <= 32'h0;
    end else if (miss && !err_flag) begin
      err_flag <= 1'b1;
      err_addr <= req_addr;
    end
  end

`ifdef DSRAM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;
  logic        is_wr;

  assign is_wr = |req_wen;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (acc && !is_wr && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (acc &&  is_wr && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - self-checking bench: fixed vectors, init/reset sequences, random vs array model
module tb_data_sram_resp;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_done, err_flag;
  logic [31:0] err_addr, rd_cnt, wr_cnt;

  data_sram_resp #(.DEPTH_LOG2(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done), .err_flag(err_flag), .err_addr(err_addr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: word array plus the values the outputs should show after each edge.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_err_addr;
  int unsigned m_rd, m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef DSRAM_PERF_CNT_EN
    return n;
`else
    return 32'h0 & n;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_rdata = 0; m_err = 0; m_err_addr = 0; m_rd = 0; m_wr = 0;
  endtask

  // Request applied in run mode: drive inputs, advance the model, wait one edge.
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int w;
    sram_en = en; sram_wen = wen; sram_addr = addr; sram_wdata = wdata;
    if (en) begin
      if (addr[31:AW+2] == 0) begin
        w = int'(addr[AW+1:2]);
        m_rdata = m_mem[w];
        if (wen == 0) m_rd++;
        else begin
          m_wr++;
          for (int b = 0; b < 4; b++)
            if (wen[b]) m_mem[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        m_rdata = 0;
        if (!m_err) begin m_err = 1; m_err_addr = addr; end
      end
    end
    @(posedge clk); #1;
    sram_en = 0;
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    rst = 1; sram_en = 0; sram_wen = 0; sram_addr = 0; sram_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata", sram_rdata, 0);
    chk("reset init_done", {31'b0, init_done}, 0);
    chk("reset err_flag", {31'b0, err_flag}, 0);
    chk("reset err_addr", err_addr, 0);
    chk("reset rd_cnt", rd_cnt, 0);
    chk("reset wr_cnt", wr_cnt, 0);

    // Start a fill, poke requests at it, then reset at init_ptr==5.
    rst = 0;
    sram_en = 1; sram_wen = 4'hF; sram_addr = 32'h0; sram_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    sram_wen = 4'h0; sram_addr = 32'h10;
    @(posedge clk); #1;
    chk("init read rdata", sram_rdata, 0);
    sram_addr = 32'h0010_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("init_done low at ptr5", {31'b0, init_done}, 0);
    chk("init miss no flag", {31'b0, err_flag}, 0);
    sram_en = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n = 0;
    while (!init_done && n < 4 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init cycles after reset", n, DEPTH);
    chk("init rd_cnt", rd_cnt, 0);
    chk("init wr_cnt", wr_cnt, 0);

    model_reset();
    drive(1, 4'h0, 32'h0, 0);
    chk("init write ignored", sram_rdata, 0);

    vecs[0]  = '{1, 4'hF, 32'h10,        32'hDEAD_BEEF, 32'h0,         0, 32'h0};
    vecs[1]  = '{1, 4'h0, 32'h10,        32'h0,         32'hDEAD_BEEF, 0, 32'h0};
    vecs[2]  = '{1, 4'h1, 32'h10,        32'h0000_00AA, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[3]  = '{1, 4'h0, 32'h10,        32'h0,         32'hDEAD_BEAA, 0, 32'h0};
    vecs[4]  = '{0, 4'h0, 32'h14,        32'h0,         32'hDEAD_BEAA, 0, 32'h0};
    vecs[5]  = '{1, 4'h0, 32'h0010_0000, 32'h0,         32'h0,         1, 32'h0010_0000};
    vecs[6]  = '{1, 4'hF, 32'h0020_0000, 32'h1234_5678, 32'h0,         1, 32'h0010_0000};
    vecs[7]  = '{1, 4'h0, 32'h10,        32'h0,         32'hDEAD_BEAA, 1, 32'h0010_0000};
    vecs[8]  = '{1, 4'h0, 32'h0,         32'h0,         32'h0,         1, 32'h0010_0000};
    vecs[9]  = '{1, 4'hA, 32'h13,        32'h1122_3344, 32'hDEAD_BEAA, 1, 32'h0010_0000};
    vecs[10] = '{1, 4'h0, 32'h10,        32'h0,         32'h11AD_33AA, 1, 32'h0010_0000};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rdata", i), sram_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err_flag", i), {31'b0, err_flag}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d err_addr", i), err_addr, vecs[i].exp_err_addr);
    end
    // 6 read hits (incl. the post-init one), 3 write hits so far.
    chk("vec rd_cnt", rd_cnt, exp_cnt(6));
    chk("vec wr_cnt", wr_cnt, exp_cnt(3));

    for (int k = 0; k < 400; k++) begin
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      en   = ($urandom_range(0, 9) < 8);
      wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin
        addr = $urandom;
        if (addr[31:AW+2] == 0) addr[31] = 1'b1;
      end else begin
        addr = {{(30-AW){1'b0}}, AW'($urandom), 2'($urandom)};
      end
      drive(en, wen, addr, $urandom);
      chk("rand rdata", sram_rdata, m_rdata);
      chk("rand err_flag", {31'b0, err_flag}, {31'b0, m_err});
      chk("rand err_addr", err_addr, m_err_addr);
    end
    chk("rand rd_cnt", rd_cnt, exp_cnt(m_rd));
    chk("rand wr_cnt", wr_cnt, exp_cnt(m_wr));

    rst = 1;
    @(posedge clk); #1;
    chk("rerst init_done", {31'b0, init_done}, 0);
    chk("rerst err_flag", {31'b0, err_flag}, 0);
    chk("rerst err_addr", err_addr, 0);
    chk("rerst rdata", sram_rdata, 0);
    chk("rerst rd_cnt", rd_cnt, 0);
    chk("rerst wr_cnt", wr_cnt, 0);
    rst = 0;
    n = 0;
    while (!init_done && n < 4 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    chk("refill cycles", n, DEPTH);
    drive(1, 4'h0, 32'h10, 0);
    chk("refill cleared word", sram_rdata, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
